// File: rtl/weight_loader.sv
// Weight-memory loader: decodes framed config beats and writes matching weights from address 0.
// Optional checksum beat after the weights is enabled with WEIGHT_LOADER_CHECKSUM_EN.
module weight_loader #(
    parameter int unsigned numWeight    = 3,
    parameter int unsigned neuronNo     = 5,
    parameter int unsigned layerNo      = 1,
    parameter int unsigned addressWidth = 10,
    parameter int unsigned dataWidth    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [dataWidth-1:0]    cfg_data,
    input  logic                    cfg_last,
    output logic                    wr_en,
    output logic [addressWidth-1:0] wr_addr,
    output logic [dataWidth-1:0]    wr_data,
    output logic                    busy,
    output logic                    load_done,
    output logic                    load_err
);

    typedef enum logic [1:0] {StIdle, StLoad, StSkip, StDone} state_e;

    localparam int unsigned CountWidth = addressWidth + 1;
    localparam logic [CountWidth-1:0] NumWeightC = CountWidth'(numWeight);
    localparam logic [7:0] LayerId  = 8'(layerNo);
    localparam logic [7:0] NeuronId = 8'(neuronNo);

    state_e                  state_q, state_d;
    logic [CountWidth-1:0]   count_q, count_d;
    logic [CountWidth-1:0]   count_inc;
    logic                    ready_q, ready_d;
    logic                    busy_q, busy_d;
    logic                    wr_en_q, wr_en_d;
    logic [addressWidth-1:0] wr_addr_q, wr_addr_d;
    logic [dataWidth-1:0]    wr_data_q, wr_data_d;
    logic                    load_done_q, load_done_d;
    logic                    load_err_q, load_err_d;
    logic                    accept;
    logic                    hdr_match;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic [dataWidth-1:0]    sum_q, sum_d;
`endif

    assign accept    = cfg_valid && ready_q;
    assign hdr_match = (cfg_data[15:8] == LayerId) && (cfg_data[7:0] == NeuronId);
    assign count_inc = count_q + CountWidth'(1);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        load_done_d = 1'b0;
        load_err_d  = load_err_q;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (hdr_match) begin
                        // A matched header that is also the last beat is an empty frame.
                        if (cfg_last) begin
                            load_err_d = 1'b1;
                        end else begin
                            load_err_d = 1'b0;
                            count_d    = '0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
                            sum_d      = '0;
`endif
                            state_d    = StLoad;
                        end
                    end else if (!cfg_last) begin
                        state_d = StSkip;
                    end
                end
            end
            StLoad: begin
                if (accept) begin
                    if (count_q < NumWeightC) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = count_q[addressWidth-1:0];
                        wr_data_d = cfg_data;
                        count_d   = count_inc;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
                        sum_d     = sum_q + cfg_data;
                        // Any last beat on a weight means the checksum is missing.
                        if (cfg_last) begin
                            load_err_d = 1'b1;
                            state_d    = StIdle;
                        end
`else
                        if (cfg_last) begin
                            if (count_inc == NumWeightC) begin
                                load_done_d = 1'b1;
                                state_d     = StDone;
                            end else begin
                                load_err_d = 1'b1;
                                state_d    = StIdle;
                            end
                        end
`endif
                    end else begin
`ifdef WEIGHT_LOADER_CHECKSUM_EN
                        // Beat after the weights is the checksum; it must also end the frame.
                        if (cfg_last && (cfg_data == sum_q)) begin
                            load_done_d = 1'b1;
                            state_d     = StDone;
                        end else begin
                            load_err_d = 1'b1;
                            state_d    = cfg_last ? StIdle : StSkip;
                        end
`else
                        load_err_d = 1'b1;
                        state_d    = cfg_last ? StIdle : StSkip;
`endif
                    end
                end
            end
            StSkip: begin
                if (accept && cfg_last) begin
                    state_d = StIdle;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign ready_d = (state_d != StDone);
    assign busy_d  = (state_d != StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            count_q     <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
        end
    end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end
`endif

    assign cfg_ready = ready_q;
    assign busy      = busy_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_weight_loader.sv
// Randomised self-checking bench for weight_loader; frame outcomes come from a whole-frame model.
module tb_weight_loader;

    localparam int unsigned N  = 3;
    localparam int unsigned AW = 10;
    localparam int unsigned DW = 16;
    localparam logic [15:0] MatchHdr = 16'h0105;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_last = 1'b0;
    logic [DW-1:0] cfg_data = '0;
    logic          cfg_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          load_done;
    logic          load_err;

    weight_loader #(
        .numWeight   (N),
        .neuronNo    (5),
        .layerNo     (1),
        .addressWidth(AW),
        .dataWidth   (DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_data (cfg_data),
        .cfg_last (cfg_last),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .load_done(load_done),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] frame_q[$];
    logic [AW-1:0] mon_addr[$];
    logic [DW-1:0] mon_data[$];
    int            mon_done;
    int            mon_ready_low;
    logic          mon_done_wr;
    logic [AW-1:0] mon_done_addr;
    logic          exp_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wr_en) begin
            mon_addr.push_back(wr_addr);
            mon_data.push_back(wr_data);
        end
        if (load_done) begin
            mon_done++;
            mon_done_wr   = wr_en;
            mon_done_addr = wr_addr;
        end
        if (rst_n && !cfg_ready) mon_ready_low++;
    end

    task automatic clear_mon();
        mon_addr.delete();
        mon_data.delete();
        mon_done      = 0;
        mon_ready_low = 0;
        mon_done_wr   = 1'b0;
        mon_done_addr = '0;
    endtask

    // Called at a negedge; returns at the negedge after the beat was accepted.
    task automatic send_beat(input logic [DW-1:0] d, input logic l);
        int guard = 0;
        int gap = $urandom_range(0, 2);
        repeat (gap) @(negedge clk);
        cfg_valid = 1'b1;
        cfg_data  = d;
        cfg_last  = l;
        while (!cfg_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_eq("ready_wait", (guard < 50), 1);
        @(negedge clk);
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        cfg_data  = DW'($urandom);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_wr_en"}, wr_en, 0);
        check_eq({tag, "_wr_addr"}, wr_addr, 0);
        check_eq({tag, "_wr_data"}, wr_data, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, load_done, 0);
        check_eq({tag, "_err"}, load_err, 0);
        check_eq({tag, "_ready"}, cfg_ready, 0);
    endtask

    // Sends header + frame_q, then judges the whole frame against the model.
    task automatic run_frame(input logic [15:0] hdr);
        int   k = frame_q.size();
        int   exp_wr = 0;
        bit   exp_done = 1'b0;
        logic matched = (hdr == MatchHdr);
        logic [DW-1:0] sum = '0;
        clear_mon();
        send_beat(DW'(hdr), (k == 0));
        if (k != 0) check_eq("busy_after_hdr", busy, 1);
        for (int i = 0; i < k; i++) send_beat(frame_q[i], (i == k - 1));
        repeat (3) @(negedge clk);

        if (matched) begin
            exp_wr = (k < N) ? k : N;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
            if (k == N + 1) begin
                for (int i = 0; i < N; i++) sum += frame_q[i];
                exp_done = (sum == frame_q[N]);
            end
`else
            exp_done = (k == N);
`endif
            exp_err = !exp_done;
        end

        check_eq("wr_count", mon_addr.size(), exp_wr);
        for (int i = 0; i < exp_wr && i < mon_addr.size(); i++) begin
            check_eq("wr_addr", mon_addr[i], i);
            check_eq("wr_data", mon_data[i], frame_q[i]);
        end
        check_eq("done_count", mon_done, exp_done ? 1 : 0);
        check_eq("ready_low_cycles", mon_ready_low, exp_done ? 1 : 0);
        if (exp_done) begin
`ifdef WEIGHT_LOADER_CHECKSUM_EN
            check_eq("done_with_wr", mon_done_wr, 0);
`else
            check_eq("done_with_wr", mon_done_wr, 1);
            check_eq("done_addr", mon_done_addr, N - 1);
`endif
        end
        check_eq("load_err", load_err, exp_err);
        check_eq("busy_idle", busy, 0);
        check_eq("ready_idle", cfg_ready, 1);
    endtask

    task automatic load_good();
        frame_q = {16'h0011, 16'h0022, 16'h0033};
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        frame_q.push_back(16'h0066);
`endif
    endtask

    initial begin
        logic [15:0] hdr;
        int          k;
        logic [DW-1:0] s;
        exp_err = 1'b0;
        clear_mon();

        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("ready_after_reset", cfg_ready, 1);

        // Good frame.
        load_good();
        run_frame(MatchHdr);

        // Other neuron: skipped, nothing written.
        frame_q = {16'h0011, 16'h0022, 16'h0033};
        run_frame(16'h0106);

        // Short frame, then a good frame clears the error.
        frame_q = {16'h0011};
        run_frame(MatchHdr);
        load_good();
        run_frame(MatchHdr);

        // Overlong frame.
        frame_q = {16'h0011, 16'h0022, 16'h0033, 16'h0044};
        run_frame(MatchHdr);

        // Empty matched frame (header carries last).
        frame_q.delete();
        run_frame(MatchHdr);

`ifdef WEIGHT_LOADER_CHECKSUM_EN
        frame_q = {16'h0011, 16'h0022, 16'h0033, 16'h0067};
        run_frame(MatchHdr);
        frame_q = {16'h0011, 16'h0022, 16'h0033};
        run_frame(MatchHdr);
        load_good();
        run_frame(MatchHdr);
`endif

        // Reset mid-frame after one weight.
        send_beat(DW'(MatchHdr), 1'b0);
        send_beat(16'h0011, 1'b0);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        exp_err = 1'b0;
        @(negedge clk);
        load_good();
        run_frame(MatchHdr);

        // Random frames.
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 1) == 1) begin
                hdr = MatchHdr;
            end else begin
                hdr = 16'($urandom);
                if (hdr == MatchHdr) hdr = 16'h0205;
            end
            k = $urandom_range(0, N + 3);
            frame_q.delete();
            for (int i = 0; i < k; i++) frame_q.push_back(DW'($urandom));
`ifdef WEIGHT_LOADER_CHECKSUM_EN
            if (k == N + 1 && $urandom_range(0, 9) < 7) begin
                s = '0;
                for (int i = 0; i < N; i++) s += frame_q[i];
                frame_q[N] = s;
            end
`else
            s = '0;
`endif
            run_frame(hdr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
